// File: rtl/step_ctrl.sv
// Run/halt/single-step clock-enable controller with debounced front-panel buttons.
// Build option: define STEP_CTRL_AUTORUN_EN to come out of reset in RUN instead of HALT.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int STEP_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_halt,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic        running,
    output logic        stepping,
    output logic [15:0] ce_count
);

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_INC    = CW'(1);
    localparam logic [7:0]    STEP_LOAD = 8'(STEP_CYCLES);

    typedef enum logic [1:0] {
        S_HALT,
        S_RUN,
        S_STEP
    } state_t;

`ifdef STEP_CTRL_AUTORUN_EN
    localparam state_t RST_STATE = S_RUN;
    localparam logic   RST_CE    = 1'b1;
`else
    localparam state_t RST_STATE = S_HALT;
    localparam logic   RST_CE    = 1'b0;
`endif

    // Button lanes packed as {halt, step, run}
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_acc;
    logic [2:0]    r_acc_d;
    logic [CW-1:0] r_db_cnt [3];
    logic [2:0]    w_press;

    assign w_raw = {btn_halt, btn_step, btn_run};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_acc   <= '0;
            r_acc_d <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_acc_d <= r_acc;
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_acc[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    // This sample is the DEBOUNCE_CYCLES-th consecutive differing one
                    r_acc[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_INC;
                end
            end
        end
    end

    assign w_press = r_acc & ~r_acc_d;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_step_cnt;
    logic [7:0] w_step_nxt;
    logic       r_cpu_ce;
    logic       r_running;
    logic       r_stepping;
    logic [15:0] r_ce_count;

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step_cnt;
        case (r_state)
            S_HALT: begin
                if (w_press[2]) begin
                    w_state_nxt = S_HALT;
                end else if (w_press[1]) begin
                    w_state_nxt = S_STEP;
                    w_step_nxt  = STEP_LOAD;
                end else if (w_press[0] && !halt_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_press[2] || halt_req) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_STEP: begin
                // halt_req deliberately not looked at here so a breakpoint can be stepped past
                if (w_press[2] || r_step_cnt <= 8'd1) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_step_nxt = r_step_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_step_cnt <= '0;
            r_cpu_ce   <= RST_CE;
            r_running  <= RST_CE;
            r_stepping <= 1'b0;
            r_ce_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_nxt;
            r_cpu_ce   <= (w_state_nxt != S_HALT);
            r_running  <= (w_state_nxt == S_RUN);
            r_stepping <= (w_state_nxt == S_STEP);
            if (r_cpu_ce) begin
                r_ce_count <= r_ce_count + 16'd1;
            end
        end
    end

    assign cpu_ce   = r_cpu_ce;
    assign running  = r_running;
    assign stepping = r_stepping;
    assign ce_count = r_ce_count;

endmodule
